// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, issues one outstanding fetch at a time,
// squashes wrong-path returns on redirect and holds the fetched word until decode accepts it.
module fetch_sequencer #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        branch_en,
  input  logic [15:0] branch_target,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [1:0]  fetch_state
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] fetch_pc, fetch_pc_n;
  logic        squash, squash_n;
  logic        if_valid_n;
  logic [31:0] if_instr_n, if_pc_n;
  logic [31:0] target;

  assign target      = {16'b0, branch_target};
  assign imem_req    = (state == ST_REQ);
  assign imem_addr   = pc;
  assign fetch_state = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_BOOT;
      pc       <= RESET_ADDR;
      fetch_pc <= 32'h0;
      squash   <= 1'b0;
      if_valid <= 1'b0;
      if_instr <= 32'h0;
      if_pc    <= 32'h0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      fetch_pc <= fetch_pc_n;
      squash   <= squash_n;
      if_valid <= if_valid_n;
      if_instr <= if_instr_n;
      if_pc    <= if_pc_n;
    end
  end

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    fetch_pc_n = fetch_pc;
    squash_n   = squash;
    if_valid_n = if_valid;
    if_instr_n = if_instr;
    if_pc_n    = if_pc;
    unique case (state)
      ST_BOOT: begin
        if (branch_en) pc_n = target;
        state_n = ST_REQ;
      end
      ST_REQ: begin
        // A redirect coinciding with a grant still takes the grant but marks its data wrong-path.
        if (imem_gnt) begin
          fetch_pc_n = pc;
          state_n    = ST_WAIT;
          if (branch_en) begin
            pc_n     = target;
            squash_n = 1'b1;
          end else begin
            pc_n     = pc + 32'd4;
            squash_n = 1'b0;
          end
        end else if (branch_en) begin
          pc_n = target;
        end
      end
      ST_WAIT: begin
        if (branch_en) begin
          pc_n     = target;
          squash_n = 1'b1;
        end
        if (imem_rvalid) begin
          if (squash || branch_en) begin
            squash_n = 1'b0;
            state_n  = ST_REQ;
          end else begin
            if_instr_n = imem_rdata;
            if_pc_n    = fetch_pc;
            if_valid_n = 1'b1;
            state_n    = ST_OUT;
          end
        end
      end
      ST_OUT: begin
        if (branch_en) begin
          if_valid_n = 1'b0;
          pc_n       = target;
          state_n    = ST_REQ;
        end else if (!stall) begin
          if_valid_n = 1'b0;
          state_n    = ST_REQ;
        end
      end
      default: state_n = ST_BOOT;
    endcase
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer; inputs change and outputs are sampled on the falling edge.
module tb_fetch_sequencer;

  logic        clk;
  logic        reset;
  logic        branch_en, stall, imem_gnt, imem_rvalid;
  logic [15:0] branch_target;
  logic [31:0] imem_rdata;
  logic        imem_req, if_valid;
  logic [31:0] imem_addr, if_instr, if_pc;
  logic [1:0]  fetch_state;

  // second instance reset to the top of the address space to exercise the PC wrap
  logic        w_gnt, w_rvalid, w_req, w_if_valid;
  logic [31:0] w_rdata, w_addr, w_if_instr, w_if_pc;
  logic [1:0]  w_state;
  logic        w_branch_en, w_stall;
  logic [15:0] w_target;

  int errors = 0;
  int checks = 0;

  fetch_sequencer dut (
    .clk(clk), .reset(reset), .branch_en(branch_en), .branch_target(branch_target),
    .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .if_valid(if_valid),
    .if_instr(if_instr), .if_pc(if_pc), .fetch_state(fetch_state)
  );

  fetch_sequencer #(.RESET_ADDR(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .reset(reset), .branch_en(w_branch_en), .branch_target(w_target),
    .stall(w_stall), .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(w_gnt),
    .imem_rvalid(w_rvalid), .imem_rdata(w_rdata), .if_valid(w_if_valid),
    .if_instr(w_if_instr), .if_pc(w_if_pc), .fetch_state(w_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++; if (fetch_state !== 2'd0) begin errors++; $display("[TB] FAIL reset_state got %0d expected 0", fetch_state); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req got %b expected 0", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_addr got %h expected 0", imem_addr); end
    checks++; if (if_valid !== 1'b0 || if_instr !== 32'h0 || if_pc !== 32'h0) begin errors++; $display("[TB] FAIL reset_if got %b/%h/%h expected 0/0/0", if_valid, if_instr, if_pc); end
    reset = 1'b1;
    tick();
    checks++; if (fetch_state !== 2'd1 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL first_req got st=%0d req=%b addr=%h expected 1/1/0", fetch_state, imem_req, imem_addr); end
  endtask

  task automatic test_sequential;
    logic [31:0] a;
    imem_gnt = 1'b1;
    for (int k = 0; k < 4; k++) begin
      a = 32'(k * 4);
      checks++; if (imem_req !== 1'b1 || imem_addr !== a) begin errors++; $display("[TB] FAIL seq_req%0d got req=%b addr=%h expected 1/%h", k, imem_req, imem_addr, a); end
      tick();
      imem_rvalid = 1'b1; imem_rdata = a ^ 32'hA5A5_A5A5;
      checks++; if (fetch_state !== 2'd2 || imem_req !== 1'b0) begin errors++; $display("[TB] FAIL seq_wait%0d got st=%0d req=%b expected 2/0", k, fetch_state, imem_req); end
      tick();
      imem_rvalid = 1'b0;
      checks++; if (if_valid !== 1'b1 || if_pc !== a || if_instr !== (a ^ 32'hA5A5_A5A5)) begin errors++; $display("[TB] FAIL seq_out%0d got v=%b pc=%h instr=%h expected 1/%h/%h", k, if_valid, if_pc, if_instr, a, a ^ 32'hA5A5_A5A5); end
      tick();
    end
    imem_gnt = 1'b0;
  endtask

  task automatic test_stall_hold;
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0; stall = 1'b1;
    for (int c = 0; c < 5; c++) begin
      checks++; if (if_valid !== 1'b1 || if_instr !== 32'hDEAD_BEEF || if_pc !== 32'h10 || imem_req !== 1'b0) begin errors++; $display("[TB] FAIL stall_hold%0d got v=%b instr=%h pc=%h req=%b expected 1/deadbeef/10/0", c, if_valid, if_instr, if_pc, imem_req); end
      tick();
    end
    stall = 1'b0;
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h14 || if_valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_release got req=%b addr=%h v=%b expected 1/14/0", imem_req, imem_addr, if_valid); end
  endtask

  task automatic test_redirect_wait;
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; branch_en = 1'b1; branch_target = 16'h0100;
    tick();
    branch_en = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0014;
    tick();
    imem_rvalid = 1'b0;
    checks++; if (if_valid !== 1'b0 || fetch_state !== 2'd1 || imem_addr !== 32'h100) begin errors++; $display("[TB] FAIL redir_wait got v=%b st=%0d addr=%h expected 0/1/100", if_valid, fetch_state, imem_addr); end
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h1111_1111;
    tick();
    imem_rvalid = 1'b0;
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h100 || if_instr !== 32'h1111_1111) begin errors++; $display("[TB] FAIL redir_wait_fetch got v=%b pc=%h instr=%h expected 1/100/11111111", if_valid, if_pc, if_instr); end
    tick();
  endtask

  task automatic test_redirect_out;
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h2222_2222;
    tick();
    imem_rvalid = 1'b0; stall = 1'b1; branch_en = 1'b1; branch_target = 16'h0040;
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h104) begin errors++; $display("[TB] FAIL redir_out_pre got v=%b pc=%h expected 1/104", if_valid, if_pc); end
    tick();
    branch_en = 1'b0; stall = 1'b0;
    checks++; if (if_valid !== 1'b0 || fetch_state !== 2'd1 || imem_addr !== 32'h40) begin errors++; $display("[TB] FAIL redir_out got v=%b st=%0d addr=%h expected 0/1/40", if_valid, fetch_state, imem_addr); end
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; branch_en = 1'b1; branch_target = 16'h0080; imem_rvalid = 1'b1; imem_rdata = 32'h3333_3333;
    tick();
    branch_en = 1'b0; imem_rvalid = 1'b0;
    checks++; if (if_valid !== 1'b0 || fetch_state !== 2'd1 || imem_addr !== 32'h80) begin errors++; $display("[TB] FAIL redir_rvalid_same got v=%b st=%0d addr=%h expected 0/1/80", if_valid, fetch_state, imem_addr); end
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h4444_4444;
    tick();
    imem_rvalid = 1'b0;
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h80 || if_instr !== 32'h4444_4444) begin errors++; $display("[TB] FAIL redir_target_fetch got v=%b pc=%h instr=%h expected 1/80/44444444", if_valid, if_pc, if_instr); end
    tick();
  endtask

  task automatic test_redirect_grant;
    imem_gnt = 1'b1; branch_en = 1'b1; branch_target = 16'h0300;
    tick();
    imem_gnt = 1'b0; branch_en = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h5555_5555;
    checks++; if (fetch_state !== 2'd2) begin errors++; $display("[TB] FAIL redir_grant_wait got st=%0d expected 2", fetch_state); end
    tick();
    imem_rvalid = 1'b0;
    checks++; if (if_valid !== 1'b0 || fetch_state !== 2'd1 || imem_addr !== 32'h300) begin errors++; $display("[TB] FAIL redir_grant got v=%b st=%0d addr=%h expected 0/1/300", if_valid, fetch_state, imem_addr); end
  endtask

  task automatic test_wrap_ungranted;
    branch_en = 1'b1; branch_target = 16'h0200;
    tick();
    branch_en = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin errors++; $display("[TB] FAIL ungranted_redir got req=%b addr=%h expected 1/200", imem_req, imem_addr); end
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin errors++; $display("[TB] FAIL ungranted_hold got req=%b addr=%h expected 1/200", imem_req, imem_addr); end
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h6666_6666;
    tick();
    imem_rvalid = 1'b0;
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h200 || if_instr !== 32'h6666_6666) begin errors++; $display("[TB] FAIL ungranted_fetch got v=%b pc=%h instr=%h expected 1/200/66666666", if_valid, if_pc, if_instr); end
    tick();
    checks++; if (w_req !== 1'b1 || w_addr !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL wrap_start got req=%b addr=%h expected 1/fffffffc", w_req, w_addr); end
    w_gnt = 1'b1;
    tick();
    w_gnt = 1'b0; w_rvalid = 1'b1; w_rdata = 32'h7777_7777;
    tick();
    w_rvalid = 1'b0;
    checks++; if (w_if_valid !== 1'b1 || w_if_pc !== 32'hFFFF_FFFC || w_if_instr !== 32'h7777_7777) begin errors++; $display("[TB] FAIL wrap_out got v=%b pc=%h instr=%h expected 1/fffffffc/77777777", w_if_valid, w_if_pc, w_if_instr); end
    tick();
    checks++; if (w_req !== 1'b1 || w_addr !== 32'h0 || w_state !== 2'd1) begin errors++; $display("[TB] FAIL wrap_addr got req=%b addr=%h st=%0d expected 1/0/1", w_req, w_addr, w_state); end
  endtask

  task automatic test_async_reset;
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    checks++; if (fetch_state !== 2'd2) begin errors++; $display("[TB] FAIL areset_pre got st=%0d expected 2", fetch_state); end
    #2 reset = 1'b0;
    #1;
    checks++; if (fetch_state !== 2'd0 || imem_req !== 1'b0 || imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL areset_ctrl got st=%0d req=%b addr=%h expected 0/0/0", fetch_state, imem_req, imem_addr); end
    checks++; if (if_valid !== 1'b0 || if_instr !== 32'h0 || if_pc !== 32'h0) begin errors++; $display("[TB] FAIL areset_if got v=%b instr=%h pc=%h expected 0/0/0", if_valid, if_instr, if_pc); end
    @(negedge clk);
    reset = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h8888_8888;
    tick();
    checks++; if (if_valid !== 1'b0 || fetch_state !== 2'd1 || imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL late_rvalid1 got v=%b st=%0d addr=%h expected 0/1/0", if_valid, fetch_state, imem_addr); end
    tick();
    imem_rvalid = 1'b0;
    checks++; if (if_valid !== 1'b0 || fetch_state !== 2'd1) begin errors++; $display("[TB] FAIL late_rvalid2 got v=%b st=%0d expected 0/1", if_valid, fetch_state); end
  endtask

  initial begin
    reset = 1'b0; branch_en = 1'b0; branch_target = 16'h0; stall = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    w_gnt = 1'b0; w_rvalid = 1'b0; w_rdata = 32'h0;
    w_branch_en = 1'b0; w_stall = 1'b0; w_target = 16'h0;
    test_reset();
    test_sequential();
    test_stall_hold();
    test_redirect_wait();
    test_redirect_out();
    test_redirect_grant();
    test_wrap_ungranted();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
